sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised single-clock FIFO with valid/ready handshakes on both sides. It is the same-domain successor to the dual-clock FIFO: generic width and depth, occupancy count, programmable almost-full/almost-empty flags, synchronous flush, and an optional registered output stage. It buffers streams between blocks sharing one clock, such as producer-to-arbiter paths and packet staging ahead of the async FIFO.

## Interface
- DATA_WIDTH, 32, payload width in bits (≥1)
- DEPTH, 8, RAM entries; power of two, ≥2
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL
- clk  in  1  single clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of contents
- w_valid  in  1  write request
- w_data  in  DATA_WIDTH  write payload
- w_ready  out  1  space available
- r_ready  in  1  consumer accepts
- r_valid  out  1  head data available
- r_data  out  DATA_WIDTH  head payload
- count  out  $clog2(DEPTH)+1  entries held, including output register when present
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL

## Operation
- Storage: DEPTH×DATA_WIDTH array. Write and read pointers are $clog2(DEPTH)+1 bits; the extra MSB is the wrap bit.
  - RAM empty when the pointers are equal.
  - RAM full when the MSBs differ and the lower bits are equal.
  - Pointers wrap DEPTH-1 → 0 and toggle the MSB.
- Write fire = w_valid & w_ready. Data is stored at wr_ptr and wr_ptr increments.
- Read fire = r_valid & r_ready. The head is consumed.
- w_ready = !full. r_valid = !empty (or output register valid, see Configuration).
- r_data is show-ahead: it is valid whenever r_valid=1 and holds while r_valid=1 & r_ready=0.
- Simultaneous write and read fire: both pointers advance and count is unchanged.
- When full, w_ready=0, so no write occurs even if a read fires in the same cycle. w_ready rises the cycle after the read.
- When empty, a write into an empty FIFO never bypasses to r_data in the same cycle.
- count increments on write-only, decrements on read-only, and is otherwise unchanged. It never exceeds capacity and never underflows.
- w_valid while w_ready=0 is legal backpressure. The producer must hold w_data.
- flush=1 (priority over all fires that cycle):
  - pointers, count and output register are cleared the next cycle;
  - the write and read in that cycle are dropped.
- rst: asynchronous clear, same result as flush.
- Reset values: w_ready=1, r_valid=0, r_data=0, count=0, almost_full=(AF_LEVEL==0), almost_empty=1.

## Timing
- Write-to-r_valid latency: 1 cycle (2 with output register).
- Read-to-w_ready recovery: 1 cycle.
- almost_full, almost_empty and count are registered or derived from registered state. They update the cycle after the fire.
- Throughput: one write and one read per cycle sustained, with no bubbles at steady state.
- Reset asserted mid-operation: outputs reach reset values without waiting for a clock edge. After deassertion, the first fire is accepted on the next posedge.

## Configuration
- SYNC_FIFO_OUTREG_EN defined:
  - a registered head stage sits after the RAM, and r_data is driven from a flop;
  - capacity is DEPTH+1 and count includes the stage;
  - the stage refills from RAM on the same edge it is consumed, so full throughput is kept;
  - empty-to-r_valid latency is 2 cycles.
- Not defined:
  - r_data = mem[rd_ptr] combinationally;
  - capacity is DEPTH;
  - latency is 1 cycle.

## Test plan
- Reset, then write 0xAAAA_0001..0003 on consecutive cycles, then hold r_ready=1. Required: r_data reads 0001, 0002, 0003 in order; r_valid rises 1 cycle after the first write (2 with the macro); count peaks at 3 and returns to 0.
- Fill DEPTH=8 with r_ready=0. Required: w_ready drops after the 8th write (9th with the macro); a 9th w_valid is not accepted; almost_full is high from count=6; count=8 (9).
- Full FIFO with w_valid=1 and r_ready=1 pulsed for 1 cycle. Required: 1 entry leaves; w_ready returns next cycle; the held word is written then; count returns to full.
- Sustained simultaneous write and read of 0..99 at half full. Required: count is constant; output is in order; no bubbles; pointers wrap more than 12 times.
- flush asserted with 5 entries and w_valid=1 in the same cycle. Required: next cycle count=0, r_valid=0, almost_empty=1; the flush-cycle write is dropped.
- rst asserted mid-stream between clock edges. Required: r_valid=0, w_ready=1 and count=0 immediately; after release, the write of 0x1234_5678 reads back correctly.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Single-clock valid/ready FIFO with count, almost flags, flush; SYNC_FIFO_OUTREG_EN adds a registered head stage.
// Write-to-r_valid 1 cycle (2 with head stage); w_ready drops when full, r_data holds while r_ready is low.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    w_valid,
  input  logic [DATA_WIDTH-1:0]   w_data,
  output logic                    w_ready,
  input  logic                    r_ready,
  output logic                    r_valid,
  output logic [DATA_WIDTH-1:0]   r_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    almost_full,
  output logic                    almost_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] AF_TH = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_TH = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ram_empty, ram_full;
  logic                  w_fire, r_fire, ram_pop;
  logic [DATA_WIDTH-1:0] ram_head;

  assign ram_empty = (wr_ptr_q == rd_ptr_q);
  assign ram_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign ram_head  = mem_q[rd_ptr_q[AW-1:0]];

  assign w_ready = !ram_full;
  assign w_fire  = w_valid & w_ready;
  assign r_fire  = r_valid & r_ready;

`ifdef SYNC_FIFO_OUTREG_EN
  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_dat_q, out_dat_d;

  // Refill the head stage on the same edge it is consumed to keep full rate.
  assign ram_pop = !ram_empty && (!out_vld_q || r_fire);
  assign r_valid = out_vld_q;
  assign r_data  = out_dat_q;

  always_comb begin
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    if (flush) begin
      out_vld_d = 1'b0;
      out_dat_d = '0;
    end else if (ram_pop) begin
      out_vld_d = 1'b1;
      out_dat_d = ram_head;
    end else if (r_fire) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
    end
  end
`else
  assign ram_pop = r_fire;
  assign r_valid = !ram_empty;
  // Gated so an empty FIFO presents zero rather than stale RAM contents.
  assign r_data  = r_valid ? ram_head : '0;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_fire)  wr_ptr_d = wr_ptr_q + PW'(1);
      if (ram_pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (w_fire && !r_fire)      count_d = count_q + CW'(1);
      else if (!w_fire && r_fire) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire && !flush) mem_q[wr_ptr_q[AW-1:0]] <= w_data;
  end

  assign count        = count_q;
  assign almost_full  = (count_q >= AF_TH);
  assign almost_empty = (count_q <= AE_TH);

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param against a queue-based reference model.
module tb_sync_fifo_param;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;
`ifdef SYNC_FIFO_OUTREG_EN
  localparam int CAP = DEPTH + 1;
  localparam int LAT = 2;
`else
  localparam int CAP = DEPTH;
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          w_valid = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          r_ready = 1'b0;
  logic          w_ready, r_valid, almost_full, almost_empty;
  logic [DW-1:0] r_data;
  logic [3:0]    count;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: contents in order plus the edge index at which each entry was written.
  logic [DW-1:0] mq[$];
  int            mt[$];
  int            edge_n = 0;

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .r_ready(r_ready), .r_valid(r_valid), .r_data(r_data),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  // Head becomes visible once it has been stored for LAT-1 further edges.
  function automatic bit m_rv();
    if (mq.size() == 0) return 1'b0;
    return (edge_n - mt[0]) >= (LAT - 1);
  endfunction

  function automatic bit m_wr();
    return mq.size() < CAP;
  endfunction

  task automatic tick();
    bit rv, wr;
    rv = m_rv();
    wr = m_wr();
    edge_n++;
    if (flush) begin
      mq.delete();
      mt.delete();
    end else begin
      if (r_ready && rv) begin
        void'(mq.pop_front());
        void'(mt.pop_front());
      end
      if (w_valid && wr) begin
        mq.push_back(w_data);
        mt.push_back(edge_n);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (w_ready !== 1'b1) begin n_bad++; $display("FAIL rst_w_ready: got %b want 1", w_ready); end
    n_cmp++; if (r_valid !== 1'b0) begin n_bad++; $display("FAIL rst_r_valid: got %b want 0", r_valid); end
    n_cmp++; if (r_data !== '0) begin n_bad++; $display("FAIL rst_r_data: got %h want 0", r_data); end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", count); end
    n_cmp++; if (almost_full !== 1'(AF == 0)) begin n_bad++; $display("FAIL rst_almost_full: got %b want %b", almost_full, AF == 0); end
    n_cmp++; if (almost_empty !== 1'b1) begin n_bad++; $display("FAIL rst_almost_empty: got %b want 1", almost_empty); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [DW-1:0] got[$];
    int max_cnt = 0;
    w_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w_data = 32'hAAAA_0001 + DW'(i);
      tick();
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (i == 0) begin
        n_cmp++; if (r_valid !== 1'(LAT == 1)) begin n_bad++; $display("FAIL basic_rv_lat1: got %b want %b", r_valid, LAT == 1); end
      end
      if (i == 1) begin
        n_cmp++; if (r_valid !== 1'b1) begin n_bad++; $display("FAIL basic_rv_lat2: got %b want 1", r_valid); end
      end
    end
    w_valid = 1'b0;
    r_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (r_valid) got.push_back(r_data);
      tick();
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    r_ready = 1'b0;
    n_cmp++; if (got.size() != 3) begin n_bad++; $display("FAIL basic_nread: got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== 32'hAAAA_0001 + DW'(i)) begin
        n_bad++; $display("FAIL basic_order[%0d]: got %h want %h", i, got[i], 32'hAAAA_0001 + DW'(i));
      end
    end
    n_cmp++; if (max_cnt != 3) begin n_bad++; $display("FAIL basic_peak: got %0d want 3", max_cnt); end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL basic_end_count: got %0d want 0", count); end
  endtask

  task automatic test_fill();
    int acc = 0;
    bit a;
    r_ready = 1'b0;
    w_valid = 1'b1;
    w_data  = 32'hF000_0000;
    for (int c = 0; c < CAP + 4; c++) begin
      n_cmp++; if (w_ready !== m_wr()) begin n_bad++; $display("FAIL fill_w_ready c%0d: got %b want %b", c, w_ready, m_wr()); end
      n_cmp++; if (almost_full !== 1'(mq.size() >= AF)) begin n_bad++; $display("FAIL fill_af c%0d: got %b want %b", c, almost_full, mq.size() >= AF); end
      n_cmp++; if (count !== 4'(mq.size())) begin n_bad++; $display("FAIL fill_count c%0d: got %0d want %0d", c, count, mq.size()); end
      a = m_wr();
      tick();
      if (a) begin acc++; w_data = w_data + 1; end
    end
    n_cmp++; if (acc != CAP) begin n_bad++; $display("FAIL fill_accepted: got %0d want %0d", acc, CAP); end
    n_cmp++; if (count !== 4'(CAP)) begin n_bad++; $display("FAIL fill_count_full: got %0d want %0d", count, CAP); end
    n_cmp++; if (w_ready !== 1'b0) begin n_bad++; $display("FAIL fill_w_ready_full: got %b want 0", w_ready); end
  endtask

  task automatic test_full_pulse();
    n_cmp++; if (r_data !== 32'hF000_0000) begin n_bad++; $display("FAIL pulse_head: got %h want f0000000", r_data); end
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    n_cmp++; if (count !== 4'(CAP - 1)) begin n_bad++; $display("FAIL pulse_count_dip: got %0d want %0d", count, CAP - 1); end
    n_cmp++; if (w_ready !== 1'b1) begin n_bad++; $display("FAIL pulse_w_ready_back: got %b want 1", w_ready); end
    n_cmp++; if (r_data !== 32'hF000_0001) begin n_bad++; $display("FAIL pulse_next_head: got %h want f0000001", r_data); end
    tick();
    w_valid = 1'b0;
    n_cmp++; if (count !== 4'(CAP)) begin n_bad++; $display("FAIL pulse_count_refull: got %0d want %0d", count, CAP); end
    n_cmp++; if (w_ready !== 1'b0) begin n_bad++; $display("FAIL pulse_w_ready_refull: got %b want 0", w_ready); end
  endtask

  task automatic test_flush();
    r_ready = 1'b1;
    for (int c = 0; c < 20 && mq.size() > 5; c++) begin
      n_cmp++; if (r_data !== mq[0]) begin n_bad++; $display("FAIL flush_drain_data: got %h want %h", r_data, mq[0]); end
      tick();
    end
    r_ready = 1'b0;
    n_cmp++; if (count !== 4'd5) begin n_bad++; $display("FAIL flush_pre_count: got %0d want 5", count); end
    flush = 1'b1; w_valid = 1'b1; r_ready = 1'b1; w_data = 32'hDEAD_BEEF;
    tick();
    flush = 1'b0; w_valid = 1'b0; r_ready = 1'b0;
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL flush_count: got %0d want 0", count); end
    n_cmp++; if (r_valid !== 1'b0) begin n_bad++; $display("FAIL flush_r_valid: got %b want 0", r_valid); end
    n_cmp++; if (almost_empty !== 1'b1) begin n_bad++; $display("FAIL flush_ae: got %b want 1", almost_empty); end
    tick();
    tick();
    n_cmp++; if (r_valid !== 1'b0 || count !== 4'd0) begin n_bad++; $display("FAIL flush_write_dropped: got rv=%b cnt=%0d want rv=0 cnt=0", r_valid, count); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp;
    w_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_data = 32'h0000_1000 + DW'(i);
      tick();
    end
    w_valid = 1'b0;
    tick();
    w_valid = 1'b1; r_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      w_data = DW'(i);
      exp = (i < 4) ? 32'h0000_1000 + DW'(i) : DW'(i - 4);
      n_cmp++; if (count !== 4'd4) begin n_bad++; $display("FAIL b2b_count i%0d: got %0d want 4", i, count); end
      n_cmp++; if (r_valid !== 1'b1 || w_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_bubble i%0d: got rv=%b wr=%b want 1 1", i, r_valid, w_ready); end
      n_cmp++; if (r_data !== exp) begin n_bad++; $display("FAIL b2b_data i%0d: got %h want %h", i, r_data, exp); end
      tick();
    end
    w_valid = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    r_ready = 1'b0;
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL b2b_drain: got %0d want 0", count); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      n_cmp++; if (w_ready !== m_wr()) begin n_bad++; $display("FAIL rnd_w_ready c%0d: got %b want %b", c, w_ready, m_wr()); end
      n_cmp++; if (r_valid !== m_rv()) begin n_bad++; $display("FAIL rnd_r_valid c%0d: got %b want %b", c, r_valid, m_rv()); end
      n_cmp++; if (count !== 4'(mq.size())) begin n_bad++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, count, mq.size()); end
      n_cmp++; if (almost_full !== 1'(mq.size() >= AF) || almost_empty !== 1'(mq.size() <= AE)) begin
        n_bad++; $display("FAIL rnd_flags c%0d: got af=%b ae=%b for size %0d", c, almost_full, almost_empty, mq.size());
      end
      if (m_rv()) begin
        n_cmp++; if (r_data !== mq[0]) begin n_bad++; $display("FAIL rnd_data c%0d: got %h want %h", c, r_data, mq[0]); end
      end
      if (!(w_valid && !m_wr())) w_data = $urandom;
      w_valid = ($urandom_range(99) < ((c < 200) ? 80 : 35));
      r_ready = ($urandom_range(99) < ((c < 200) ? 35 : 80));
      flush   = ($urandom_range(59) == 0);
      tick();
    end
    flush = 1'b0; w_valid = 1'b0; r_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    bit seen = 1'b0;
    w_valid = 1'b1; r_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_data = $urandom;
      tick();
    end
    r_ready = 1'b1;
    tick();
    #2;
    rst = 1'b1;
    mq.delete();
    mt.delete();
    #1;
    n_cmp++; if (r_valid !== 1'b0) begin n_bad++; $display("FAIL arst_r_valid: got %b want 0", r_valid); end
    n_cmp++; if (w_ready !== 1'b1) begin n_bad++; $display("FAIL arst_w_ready: got %b want 1", w_ready); end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL arst_count: got %0d want 0", count); end
    w_valid = 1'b0; r_ready = 1'b0;
    #1;
    rst = 1'b0;
    w_valid = 1'b1;
    w_data  = 32'h1234_5678;
    tick();
    w_valid = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      if (r_valid) begin
        seen = 1'b1;
        n_cmp++; if (r_data !== 32'h1234_5678) begin n_bad++; $display("FAIL arst_readback: got %h want 12345678", r_data); end
      end else begin
        tick();
      end
    end
    if (!seen) begin
      n_cmp++; n_bad++; $display("FAIL arst_readback_timeout: got r_valid=0 want 1");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_full_pulse();
    test_flush();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
